checkout_scheduler: RTL and testbench
=====================================

# checkout_scheduler

Sequences the single shared fare/payment datapath (`vending_machine_datapath`) among `N_SPOTS` parking spots requesting checkout. Arbitrates requests round-robin and muxes the granted spot's `start`/`final1`/`size` into the datapath. Drives `calculate_fare`/`receiving`/`resetting`, then waits for `leave` or a timeout. Sits between the spot array and the datapath, replacing direct wiring of one spot to the payment path.

## Interface
Parameters:
- `N_SPOTS`, 4: number of requesting spots (≥2).
- `ID_W`, `$clog2(N_SPOTS)`: spot index width.
- `TIMEOUT_CYCLES`, 1000: maximum cycles in COLLECT before abort (≥2).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `req`  in  N_SPOTS  level checkout request per spot; held until that spot's `done`/`abort`.
- `spot_start`  in  9*N_SPOTS  packed per-spot entry hour (spot i at [9i+8:9i]).
- `spot_final`  in  9*N_SPOTS  packed per-spot exit hour.
- `spot_size`  in  2*N_SPOTS  packed per-spot size code.
- `leave`  in  1  from datapath: sum ≥ fare.
- `sel_start`  out  9  granted spot's start; 0 when no grant.
- `sel_final`  out  9  granted spot's final; 0 when no grant.
- `sel_size`  out  2  granted spot's size; 0 when no grant.
- `calculate_fare`  out  1  to datapath.
- `receiving`  out  1  to datapath.
- `resetting`  out  1  to datapath; clears running sum.
- `grant`  out  N_SPOTS  one-hot granted spot; 0 when idle.
- `busy`  out  1  not in IDLE.
- `done`  out  1  one-cycle pulse: granted spot paid.
- `abort`  out  1  one-cycle pulse: timeout or request withdrawn.
- `done_id`  out  ID_W  spot index qualifying `done`/`abort`.

## Operation
- States: CLEAR, IDLE, LOAD, COLLECT, RELEASE, ABORT.
- Registered state; all outputs are decodes of state plus registered `gnt_id`.
- CLEAR (reset state): `resetting`=1 for one cycle, then IDLE.
- IDLE: if any `req` bit set, pick the first set bit searching upward (with wrap) from `rr_ptr+1`. Register `gnt_id`, go to LOAD; else stay.
- LOAD: `grant`/`sel_*` valid, `calculate_fare`=1, `receiving`=0; one cycle for fare to settle. Clear timeout counter. Go to COLLECT.
- COLLECT: `calculate_fare`=1, `receiving`=1; counter increments each cycle.
  - `leave`=1 → RELEASE.
  - Else `req[gnt_id]`=0 → ABORT.
  - Else counter == `TIMEOUT_CYCLES-1` → ABORT.
  - Priority: `leave` > withdraw > timeout.
- RELEASE: `done`=1, `resetting`=1, `rr_ptr`←`gnt_id`, then IDLE.
- ABORT: `abort`=1, `resetting`=1, `rr_ptr`←`gnt_id`, then IDLE.
- `grant`, `sel_*`, `done_id` hold `gnt_id` from LOAD through RELEASE/ABORT inclusive; zero in CLEAR/IDLE.
- `busy`=1 in LOAD, COLLECT, RELEASE, ABORT.
- Counter width: `$clog2(TIMEOUT_CYCLES)`; saturates and never wraps.
- `req` changes on non-granted spots during service are ignored until IDLE.

## Timing
- Reset values while `resetn`=0:
  - State is CLEAR, so `resetting`=1.
  - All other outputs 0.
  - `rr_ptr`=N_SPOTS-1, so spot 0 has first priority.
  - Counter 0.
- Reset asserted mid-service: immediate return to CLEAR; no `done`/`abort` emitted.
- Latency: `req` set in IDLE at edge k → `grant` at edge k+1 (LOAD) → `receiving` at k+2.
- Minimum service: `leave` high on first COLLECT cycle gives `done` at k+3, IDLE at k+4.
- Timeout: COLLECT lasts exactly `TIMEOUT_CYCLES` cycles, then one ABORT cycle.
- One IDLE cycle between consecutive grants, even with pending requests. This guarantees `resetting` deasserts before the next `receiving`.

## Structure
- Shared package holds:
  - State encoding constants (CLEAR=0, IDLE=1, LOAD=2, COLLECT=3, RELEASE=4, ABORT=5; 3 bits).
  - Size codes (small=2'b10, medium=2'b01, large=2'b11).
- One sub-module: `rr_arbiter`, combinational. Inputs `req`, `rr_ptr`; outputs `found`, `pick_id`. Scheduler FSM, counter and muxes stay in the top.

## Test plan
- Reset: hold `resetn`=0 → `resetting`=1, `grant`=0, `busy`=0; release → one CLEAR cycle, then `resetting`=0, IDLE.
- Single request: `req`=4'b0100, spot 2 start=70, final=72, `leave` rises 5 cycles into COLLECT → `grant`=4'b0100, `sel_start`=70, `sel_final`=72, `done`=1 with `done_id`=2, `resetting`=1 same cycle.
- Round-robin: `req`=4'b1011 held, each service ended by `leave` → grant order 0,1,3,0.
- Timeout: `TIMEOUT_CYCLES`=8, `req`=4'b0001, `leave`=0 → `receiving` high exactly 8 cycles, then `abort`=1 with `done_id`=0.
- Withdraw vs leave: `req[1]` drops in the same cycle `leave`=1 → `done`, not `abort`. Repeat with `leave`=0 → `abort` next cycle.
- Mid-service reset: assert `resetn`=0 during COLLECT → outputs at reset values immediately, no `done`/`abort`. Spot 0 is next granted.

Source files
------------

// File: rtl/checkout_scheduler_pkg.sv
// Shared definitions for the checkout scheduler: FSM state encoding and
// the size codes carried from each spot to the fare datapath.
package checkout_scheduler_pkg;

    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        IDLE    = 3'd1,
        LOAD    = 3'd2,
        COLLECT = 3'd3,
        RELEASE = 3'd4,
        ABORT   = 3'd5
    } state_t;

    localparam logic [1:0] SIZE_SMALL  = 2'b10;
    localparam logic [1:0] SIZE_MEDIUM = 2'b01;
    localparam logic [1:0] SIZE_LARGE  = 2'b11;

endpackage

// File: rtl/checkout_scheduler_rr_arbiter.sv
// Combinational round-robin picker: finds the first set request bit
// searching upward, with wrap, starting one past the last served spot.
module rr_arbiter #(
    parameter int N_SPOTS = 4,
    parameter int ID_W    = $clog2(N_SPOTS)
) (
    input  logic [N_SPOTS-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    pick_id
);

    // Walk distances from farthest to nearest so the nearest hit wins.
    always_comb begin
        found   = 1'b0;
        pick_id = '0;
        for (int i = N_SPOTS; i >= 1; i--) begin
            for (int j = 0; j < N_SPOTS; j++) begin
                if (req[j] && ((int'(rr_ptr) + i) % N_SPOTS) == j) begin
                    found   = 1'b1;
                    pick_id = ID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/checkout_scheduler.sv
// Shares one fare/payment datapath among several parking spots: picks a
// spot round-robin, steers its data to the datapath and sequences payment.
module checkout_scheduler
    import checkout_scheduler_pkg::*;
#(
    parameter int N_SPOTS        = 4,
    parameter int ID_W           = $clog2(N_SPOTS),
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [N_SPOTS-1:0]   req,
    input  logic [9*N_SPOTS-1:0] spot_start,
    input  logic [9*N_SPOTS-1:0] spot_final,
    input  logic [2*N_SPOTS-1:0] spot_size,
    input  logic                 leave,
    output logic [8:0]           sel_start,
    output logic [8:0]           sel_final,
    output logic [1:0]           sel_size,
    output logic                 calculate_fare,
    output logic                 receiving,
    output logic                 resetting,
    output logic [N_SPOTS-1:0]   grant,
    output logic                 busy,
    output logic                 done,
    output logic                 abort,
    output logic [ID_W-1:0]      done_id
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              found;
    logic [ID_W-1:0]   pick_id;
    logic              gnt_req;
    logic              active;

    rr_arbiter #(
        .N_SPOTS (N_SPOTS),
        .ID_W    (ID_W)
    ) u_arbiter (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .found   (found),
        .pick_id (pick_id)
    );

    // rr_ptr resets to the top spot so spot 0 is first in line.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= CLEAR;
            gnt_id_q <= '0;
            rr_ptr_q <= ID_W'(N_SPOTS - 1);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        gnt_req = 1'b0;
        for (int j = 0; j < N_SPOTS; j++) begin
            if (gnt_id_q == ID_W'(j)) gnt_req = req[j];
        end
    end

    // Leaving beats withdrawal, which beats the timeout.
    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            CLEAR: state_d = IDLE;
            IDLE: begin
                if (found) begin
                    gnt_id_d = pick_id;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = COLLECT;
            end
            COLLECT: begin
                cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
                if (leave)                 state_d = RELEASE;
                else if (!gnt_req)         state_d = ABORT;
                else if (cnt_q == CNT_LAST) state_d = ABORT;
            end
            RELEASE, ABORT: begin
                rr_ptr_d = gnt_id_q;
                state_d  = IDLE;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        active         = state_q inside {LOAD, COLLECT, RELEASE, ABORT};
        grant          = '0;
        sel_start      = '0;
        sel_final      = '0;
        sel_size       = '0;
        for (int j = 0; j < N_SPOTS; j++) begin
            if (active && gnt_id_q == ID_W'(j)) begin
                grant[j]  = 1'b1;
                sel_start = spot_start[9*j +: 9];
                sel_final = spot_final[9*j +: 9];
                sel_size  = spot_size[2*j +: 2];
            end
        end
        done_id        = active ? gnt_id_q : '0;
        busy           = active;
        calculate_fare = (state_q == LOAD) || (state_q == COLLECT);
        receiving      = (state_q == COLLECT);
        resetting      = state_q inside {CLEAR, RELEASE, ABORT};
        done           = (state_q == RELEASE);
        abort          = (state_q == ABORT);
    end

endmodule

// File: tb/tb_checkout_scheduler.sv
// Scoreboard bench for checkout_scheduler: directed services push expected
// done/abort outcomes, a monitor pops and checks them as pulses appear.
module tb_checkout_scheduler;
    import checkout_scheduler_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic        clock;
    logic        resetn;
    logic [3:0]  req;
    logic [35:0] spot_start;
    logic [35:0] spot_final;
    logic [7:0]  spot_size;
    logic        leave;
    logic [8:0]  sel_start;
    logic [8:0]  sel_final;
    logic [1:0]  sel_size;
    logic        calculate_fare;
    logic        receiving;
    logic        resetting;
    logic [3:0]  grant;
    logic        busy;
    logic        done;
    logic        abort;
    logic [1:0]  done_id;

    typedef struct {
        logic isAbort;
        int   id;
    } expect_t;

    expect_t    expQ[$];
    int         assertCount = 0;
    int         failCount   = 0;
    logic [8:0] startTab [4];
    logic [8:0] finalTab [4];
    logic [1:0] sizeTab  [4];

    checkout_scheduler #(
        .N_SPOTS        (N),
        .ID_W           (2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .req            (req),
        .spot_start     (spot_start),
        .spot_final     (spot_final),
        .spot_size      (spot_size),
        .leave          (leave),
        .sel_start      (sel_start),
        .sel_final      (sel_final),
        .sel_size       (sel_size),
        .calculate_fare (calculate_fare),
        .receiving      (receiving),
        .resetting      (resetting),
        .grant          (grant),
        .busy           (busy),
        .done           (done),
        .abort          (abort),
        .done_id        (done_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every done/abort pulse must match the oldest queued expectation.
    initial begin
        expect_t e;
        forever begin
            @(negedge clock);
            if (done || abort) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pulse", 32'({done, abort}), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("pulse_kind", 32'({done, abort}), e.isAbort ? 32'd1 : 32'd2);
                    checkOutput("pulse_id", 32'(done_id), 32'(e.id));
                    checkOutput("pulse_grant", 32'(grant), 32'(4'b0001 << e.id));
                    checkOutput("pulse_start", 32'(sel_start), 32'(startTab[e.id]));
                    checkOutput("pulse_final", 32'(sel_final), 32'(finalTab[e.id]));
                    checkOutput("pulse_size", 32'(sel_size), 32'(sizeTab[e.id]));
                    checkOutput("pulse_resetting", 32'(resetting), 32'd1);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Called at an IDLE negedge; returns at the IDLE negedge after the service.
    task automatic applyStimulus(input logic [3:0] reqBits, input int expId,
                                 input int collectCycles, input logic endWithLeave,
                                 input logic dropReq, input logic expAbort);
        expect_t e;
        e.isAbort = expAbort;
        e.id      = expId;
        expQ.push_back(e);
        req = reqBits;
        @(negedge clock);
        checkOutput("load_grant", 32'(grant), 32'(4'b0001 << expId));
        checkOutput("load_sel_start", 32'(sel_start), 32'(startTab[expId]));
        checkOutput("load_ctrl", 32'({calculate_fare, receiving, busy}), 32'd5);
        for (int c = 1; c <= collectCycles; c++) begin
            @(negedge clock);
            checkOutput("collect_recv", 32'({calculate_fare, receiving}), 32'd3);
            if (c == collectCycles) begin
                leave = endWithLeave;
                if (dropReq) req = 4'b0000;
            end
        end
        @(negedge clock);
        checkOutput("end_done", 32'(done), 32'(!expAbort));
        checkOutput("end_abort", 32'(abort), 32'(expAbort));
        checkOutput("end_resetting", 32'(resetting), 32'd1);
        leave = 1'b0;
        @(negedge clock);
        checkOutput("idle_gap", 32'({busy, grant, done_id, resetting, receiving}), 32'd0);
        checkOutput("idle_sel", 32'({sel_start, sel_final, sel_size}), 32'd0);
    endtask

    initial begin
        int recvCount;
        expect_t e;
        startTab = '{9'd5, 9'd20, 9'd70, 9'd100};
        finalTab = '{9'd9, 9'd23, 9'd72, 9'd110};
        sizeTab  = '{SIZE_SMALL, SIZE_MEDIUM, SIZE_LARGE, SIZE_SMALL};
        for (int i = 0; i < N; i++) begin
            spot_start[9*i +: 9] = startTab[i];
            spot_final[9*i +: 9] = finalTab[i];
            spot_size[2*i +: 2]  = sizeTab[i];
        end
        resetn = 1'b0;
        req    = 4'b0000;
        leave  = 1'b0;

        @(negedge clock);
        checkOutput("reset_resetting", 32'(resetting), 32'd1);
        checkOutput("reset_others", 32'({grant, busy, done, abort, receiving, calculate_fare, done_id}), 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        checkOutput("post_clear_idle", 32'({resetting, busy}), 32'd0);

        // Round-robin with all of 0,1,3 held.
        applyStimulus(4'b1011, 0, 1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1011, 1, 2, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1011, 3, 1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1011, 0, 3, 1'b1, 1'b0, 1'b0);
        req = 4'b0000;

        applyStimulus(4'b0100, 2, 5, 1'b1, 1'b0, 1'b0);
        req = 4'b0000;

        // Timeout: count COLLECT cycles until the abort pulse.
        e.isAbort = 1'b1;
        e.id      = 0;
        expQ.push_back(e);
        req = 4'b0001;
        @(negedge clock);
        checkOutput("tmo_grant", 32'(grant), 32'd1);
        recvCount = 0;
        for (int c = 0; c < 3 * TMO; c++) begin
            @(negedge clock);
            if (!receiving) break;
            recvCount++;
        end
        checkOutput("tmo_recv_cycles", 32'(recvCount), 32'(TMO));
        checkOutput("tmo_abort", 32'({abort, done_id}), 32'b100);
        req = 4'b0000;
        @(negedge clock);
        checkOutput("tmo_idle", 32'(busy), 32'd0);

        // Withdraw together with leave, then withdraw alone.
        applyStimulus(4'b0010, 1, 1, 1'b1, 1'b1, 1'b0);
        applyStimulus(4'b0010, 1, 1, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of COLLECT.
        req = 4'b0100;
        @(negedge clock);
        checkOutput("mid_load_grant", 32'(grant), 32'b0100);
        @(negedge clock);
        @(negedge clock);
        checkOutput("mid_collect", 32'(receiving), 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("mid_reset_resetting", 32'(resetting), 32'd1);
        checkOutput("mid_reset_others", 32'({grant, busy, done, abort, receiving, calculate_fare, sel_start}), 32'd0);
        req = 4'b0000;
        @(negedge clock);
        checkOutput("mid_reset_hold", 32'({busy, done, abort}), 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        checkOutput("mid_post_clear", 32'({resetting, busy}), 32'd0);
        applyStimulus(4'b0111, 0, 1, 1'b1, 1'b1, 1'b0);

        repeat (2) @(negedge clock);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
